// File: rtl/hex_stack_pkg.sv
// Shared constants and operation encoding for the hex digit stack.
package hex_stack_pkg;

    localparam int unsigned DIGIT_W = 4;

    // One operation per cycle, chosen by the priority decoder.
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_CLR  = 3'd1,
        OP_SET  = 3'd2,
        OP_UNDO = 3'd3,
        OP_ADD  = 3'd4,
        OP_DEL  = 3'd5
    } op_e;

endpackage

// File: rtl/hist_ring.sv
// LIFO ring of undo entries; a push when full silently overwrites the oldest entry.
module hist_ring #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ENTRY_W = 36
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic                             pop,
    input  logic [ENTRY_W-1:0]               push_data,
    output logic [ENTRY_W-1:0]               top_data,
    output logic [$clog2(DEPTH+1)-1:0]       cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned HW = $clog2(DEPTH+1);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [HW-1:0]      cnt_q, cnt_d;

    // Pointer wraps naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (cnt_q != HW'(DEPTH)) begin
                cnt_d = cnt_q + HW'(1);
            end
        end else if (pop && (cnt_q != '0)) begin
            wr_ptr_d = wr_ptr_q - PW'(1);
            cnt_d    = cnt_q - HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Contents are only invalidated by reset, never cleared.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign top_data = mem_q[wr_ptr_q - PW'(1)];
    assign cnt      = cnt_q;

endmodule

// File: rtl/hex_digit_stack.sv
// Shift-register of hex digits with add/del/set/clr and a bounded undo history.
module hex_digit_stack
    import hex_stack_pkg::*;
#(
    parameter int unsigned DIGITS     = 8,
    parameter int unsigned HIST_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [3:0]                          hex,
    input  logic                                add,
    input  logic                                del,
    input  logic                                set,
    input  logic                                clr,
    input  logic                                undo,
    input  logic [4*DIGITS-1:0]                 din,
    output logic [4*DIGITS-1:0]                 dout,
    output logic [$clog2(DIGITS+1)-1:0]         count,
    output logic                                full,
    output logic                                empty,
    output logic                                ovf,
    output logic [$clog2(HIST_DEPTH+1)-1:0]     hist_cnt
);

    localparam int unsigned W  = DIGIT_W * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS+1);
    localparam int unsigned HW = $clog2(HIST_DEPTH+1);
    localparam int unsigned EW = W + CW;

    op_e            op;
    logic [W-1:0]   dout_q, dout_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;
    logic [CW-1:0]  set_count;
    logic           push, pop;
    logic [EW-1:0]  top_data;
    logic [HW-1:0]  hist_cnt_w;
    logic           is_full;

    assign is_full = (count_q == CW'(DIGITS));

    // Priority decode: clr > set > undo > add > del.
    always_comb begin
        op = OP_NONE;
        if (clr) begin
            op = OP_CLR;
        end else if (set) begin
            op = OP_SET;
        end else if (undo) begin
            op = OP_UNDO;
        end else if (add) begin
            op = OP_ADD;
        end else if (del) begin
            op = OP_DEL;
        end
    end

    // Significant digits of din: highest nonzero digit index plus one.
    always_comb begin
        set_count = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (din[i*DIGIT_W +: DIGIT_W] != '0) begin
                set_count = CW'(i + 1);
            end
        end
    end

    always_comb begin
        dout_d  = dout_q;
        count_d = count_q;
        ovf_d   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        case (op)
            OP_CLR: begin
                push    = 1'b1;
                dout_d  = '0;
                count_d = '0;
            end
            OP_SET: begin
                push    = 1'b1;
                dout_d  = din;
                count_d = set_count;
            end
            OP_UNDO: begin
                if (hist_cnt_w != '0) begin
                    pop               = 1'b1;
                    {dout_d, count_d} = top_data;
                end
            end
            OP_ADD: begin
                push = 1'b1;
                // A leading zero on an empty stack is recorded but changes nothing.
                if (!((count_q == '0) && (hex == '0))) begin
                    dout_d  = {dout_q[W-DIGIT_W-1:0], hex};
                    count_d = is_full ? count_q : count_q + CW'(1);
                    ovf_d   = is_full && (dout_q[W-1 -: DIGIT_W] != '0);
                end
            end
            OP_DEL: begin
                if (count_q != '0) begin
                    push    = 1'b1;
                    dout_d  = dout_q >> DIGIT_W;
                    count_d = count_q - CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    hist_ring #(
        .DEPTH   (HIST_DEPTH),
        .ENTRY_W (EW)
    ) u_hist_ring (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data ({dout_q, count_q}),
        .top_data  (top_data),
        .cnt       (hist_cnt_w)
    );

    assign dout     = dout_q;
    assign count    = count_q;
    assign full     = is_full;
    assign empty    = (count_q == '0);
    assign ovf      = ovf_q;
    assign hist_cnt = hist_cnt_w;

endmodule

// File: tb/tb_hex_digit_stack.sv
// Directed self-checking bench for hex_digit_stack (DIGITS=8, HIST_DEPTH=4).
module tb_hex_digit_stack;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  hex;
    logic        add, del, set, clr, undo;
    logic [31:0] din;
    logic [31:0] dout;
    logic [3:0]  count;
    logic        full, empty, ovf;
    logic [2:0]  hist_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hex_digit_stack #(.DIGITS(8), .HIST_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .hex      (hex),
        .add      (add),
        .del      (del),
        .set      (set),
        .clr      (clr),
        .undo     (undo),
        .din      (din),
        .dout     (dout),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .ovf      (ovf),
        .hist_cnt (hist_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of strobes on the falling edge; return 1ns after the rising edge.
    task automatic cyc(input logic r, input logic a, input logic d, input logic s,
                       input logic c, input logic u, input logic [3:0] h, input logic [31:0] v);
        @(negedge clk);
        rst = r; add = a; del = d; set = s; clr = c; undo = u; hex = h; din = v;
        @(posedge clk);
        #1;
        rst = 0; add = 0; del = 0; set = 0; clr = 0; undo = 0; hex = 0; din = 0;
    endtask

    task automatic do_add(input logic [3:0] h);  cyc(0, 1, 0, 0, 0, 0, h, 0); endtask
    task automatic do_del();                     cyc(0, 0, 1, 0, 0, 0, 0, 0); endtask
    task automatic do_set(input logic [31:0] v); cyc(0, 0, 0, 1, 0, 0, 0, v); endtask
    task automatic do_clr();                     cyc(0, 0, 0, 0, 1, 0, 0, 0); endtask
    task automatic do_undo();                    cyc(0, 0, 0, 0, 0, 1, 0, 0); endtask
    task automatic do_idle();                    cyc(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_rst();                     cyc(1, 0, 0, 0, 0, 0, 0, 0); endtask

    task automatic st(input string tag, input logic [31:0] d, input logic [3:0] c,
                      input logic [2:0] h);
        chk({tag, ".dout"}, dout, d);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".hist"}, 32'(hist_cnt), 32'(h));
    endtask

    initial begin
        rst = 0; add = 0; del = 0; set = 0; clr = 0; undo = 0; hex = 0; din = 0;
        do_rst();
        do_rst();
        st("reset", 32'h0, 4'd0, 3'd0);
        chk("reset.empty", 32'(empty), 32'd1);
        chk("reset.full", 32'(full), 32'd0);
        chk("reset.ovf", 32'(ovf), 32'd0);

        do_add(4'h1); do_add(4'h2); do_add(4'h3);
        st("add123", 32'h0000_0123, 4'd3, 3'd3);

        do_set(32'h0000_A000);
        st("setA000", 32'h0000_A000, 4'd4, 3'd4);
        do_del(); do_del();
        st("del2", 32'h0000_00A0, 4'd2, 3'd4);

        do_clr();
        st("clr", 32'h0, 4'd0, 3'd4);
        do_del();
        st("del_empty", 32'h0, 4'd0, 3'd4);
        chk("del_empty.empty", 32'(empty), 32'd1);

        do_set(32'h9ABC_DEF0);
        st("set_full", 32'h9ABC_DEF0, 4'd8, 3'd4);
        chk("set_full.full", 32'(full), 32'd1);
        do_add(4'h5);
        st("add_ovf", 32'hABCD_EF05, 4'd8, 3'd4);
        chk("add_ovf.ovf", 32'(ovf), 32'd1);
        do_idle();
        chk("ovf_pulse_end", 32'(ovf), 32'd0);

        // Five adds, then five undos against a 4-deep history.
        do_rst();
        do_add(4'h1); do_add(4'h2); do_add(4'h3); do_add(4'h4); do_add(4'h5);
        st("five_ops", 32'h0001_2345, 4'd5, 3'd4);
        do_undo(); st("undo1", 32'h0000_1234, 4'd4, 3'd3);
        do_undo(); st("undo2", 32'h0000_0123, 4'd3, 3'd2);
        do_undo(); st("undo3", 32'h0000_0012, 4'd2, 3'd1);
        do_undo(); st("undo4", 32'h0000_0001, 4'd1, 3'd0);
        do_undo(); st("undo5", 32'h0000_0001, 4'd1, 3'd0);

        do_add(4'h2);
        st("pre_multi", 32'h0000_0012, 4'd2, 3'd1);
        cyc(0, 1, 1, 0, 1, 0, 4'h7, 0);
        st("clr_wins", 32'h0, 4'd0, 3'd2);
        do_undo();
        st("undo_clr", 32'h0000_0012, 4'd2, 3'd1);
        cyc(0, 1, 0, 0, 0, 1, 4'hF, 0);
        st("undo_over_add", 32'h0000_0001, 4'd1, 3'd0);
        cyc(0, 1, 0, 1, 0, 0, 4'hF, 32'h0000_0300);
        st("set_over_add", 32'h0000_0300, 4'd3, 3'd1);

        do_clr();
        do_add(4'h0);
        st("add0_empty", 32'h0, 4'd0, 3'd3);
        do_undo();
        st("undo_add0", 32'h0, 4'd0, 3'd2);

        do_set(32'h0FFF_FFFF);
        st("set7", 32'h0FFF_FFFF, 4'd7, 3'd3);
        do_add(4'h1);
        st("add_to_full", 32'hFFFF_FFF1, 4'd8, 3'd4);
        chk("add_to_full.ovf", 32'(ovf), 32'd0);
        do_add(4'h2);
        st("add_ovf2", 32'hFFFF_FF12, 4'd8, 3'd4);
        chk("add_ovf2.ovf", 32'(ovf), 32'd1);

        do_set(32'h0);
        st("set_zero", 32'h0, 4'd0, 3'd4);

        do_add(4'h3);
        st("pre_rst", 32'h0000_0003, 4'd1, 3'd4);
        cyc(1, 1, 0, 0, 0, 0, 4'h9, 0);
        st("rst_add", 32'h0, 4'd0, 3'd0);
        chk("rst_add.empty", 32'(empty), 32'd1);
        chk("rst_add.ovf", 32'(ovf), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
